// File: rtl/seg_scroll_sequencer.sv
// seg_scroll_sequencer: bus-mapped 16-digit message scroller for the 4-digit display.
// Optional feature macro SEQ_BOUNCE_EN implements CTRL bit2 (ping-pong scrolling).
module seg_scroll_sequencer #(
  parameter logic [7:0]  BaseAddr = 8'hE0,
  parameter int unsigned PRESCALE = 100000
) (
  input  logic       CLK,
  input  logic       RESET,
  inout  wire  [7:0] BUS_DATA,
  input  logic [7:0] BUS_ADDR,
  input  logic       BUS_WE,
  output logic [4:0] DIGIT_A,
  output logic [4:0] DIGIT_B,
  output logic [4:0] DIGIT_C,
  output logic [4:0] DIGIT_D,
  output logic       BUSY,
  output logic       DONE_IRQ
);

  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] PRE_MAX = PW'(PRESCALE - 1);
`ifdef SEQ_BOUNCE_EN
  localparam logic [2:0] CTRL_MASK = 3'b111;
`else
  localparam logic [2:0] CTRL_MASK = 3'b011;
`endif

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t        state, state_nx;
  logic [2:0]    ctrl;
  logic [7:0]    period;
  logic [4:0]    len;
  logic          done_flag;
  logic [3:0]    pos, pos_nx;
  logic [PW-1:0] pre_cnt;
  logic [7:0]    per_cnt;
  logic [4:0]    msg [16];
  logic          drive;
  logic [7:0]    rd_data, rd_mux;
`ifdef SEQ_BOUNCE_EN
  logic          dir, dir_nx;
  logic          bounce_n;
  logic [4:0]    top;
`endif

  function automatic logic [4:0] clamp_len(input logic [4:0] v);
    if (v < 5'd4) return 5'd4;
    if (v > 5'd16) return 5'd16;
    return v;
  endfunction

  function automatic logic [3:0] win_idx(input logic [3:0] p,
                                         input logic [4:0] k,
                                         input logic [4:0] l);
    logic [4:0] s;
    s = {1'b0, p} + k;
    return 4'(s % l);
  endfunction

  logic [7:0] off;
  logic [3:0] midx;
  logic       in_win, wr;
  logic       wr_ctrl, wr_per, wr_len, wr_stat, wr_msg;
  logic       oneshot_n, en_rise, en_fall;
  logic [7:0] period_n, per_eff;
  logic [4:0] len_n, eff_len, cur_len;
  logic       tick, step, last, finish;

  assign off     = BUS_ADDR - BaseAddr;
  assign midx    = 4'(off - 8'd8);
  assign in_win  = (BUS_ADDR >= BaseAddr) && (off < 8'd24);
  assign wr      = in_win && BUS_WE;
  assign wr_ctrl = wr && (off == 8'd0);
  assign wr_per  = wr && (off == 8'd1);
  assign wr_len  = wr && (off == 8'd2);
  assign wr_stat = wr && (off == 8'd3);
  assign wr_msg  = wr && (off >= 8'd8);

  // Steps on a write edge see the freshly written CTRL/PERIOD/LEN.
  assign oneshot_n = wr_ctrl ? BUS_DATA[1] : ctrl[1];
  assign period_n  = wr_per ? BUS_DATA : period;
  assign len_n     = wr_len ? BUS_DATA[4:0] : len;
  assign eff_len   = clamp_len(len_n);
  assign cur_len   = clamp_len(len);
  assign per_eff   = (period_n == 8'd0) ? 8'd1 : period_n;
`ifdef SEQ_BOUNCE_EN
  assign bounce_n  = wr_ctrl ? BUS_DATA[2] : ctrl[2];
  assign top       = eff_len - 5'd4;
`endif

  assign en_rise = wr_ctrl && BUS_DATA[0] && (state != S_RUN);
  assign en_fall = wr_ctrl && !BUS_DATA[0];
  assign tick    = (state == S_RUN) && (pre_cnt == PRE_MAX);
  assign step    = tick && (({1'b0, per_cnt} + 9'd1) >= {1'b0, per_eff});
  assign last    = {1'b0, pos} >= (eff_len - 5'd4);
  assign finish  = (state == S_RUN) && !en_fall && step && oneshot_n && last;

  // State register.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) state <= S_IDLE;
    else       state <= state_nx;
  end

  // Next-state logic.
  always_comb begin
    state_nx = state;
    unique case (state)
      S_IDLE: if (en_rise) state_nx = S_RUN;
      S_RUN: begin
        if (en_fall)     state_nx = S_IDLE;
        else if (finish) state_nx = S_DONE;
      end
      S_DONE: begin
        if (en_fall)      state_nx = S_IDLE;
        else if (en_rise) state_nx = S_RUN;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  // State-decoded outputs.
  always_comb begin
    BUSY = (state == S_RUN);
  end

  // Next scroll position (and bounce direction).
  always_comb begin
    pos_nx = pos;
`ifdef SEQ_BOUNCE_EN
    dir_nx = dir;
`endif
    if (en_rise) begin
      pos_nx = 4'd0;
`ifdef SEQ_BOUNCE_EN
      dir_nx = 1'b1;
`endif
    end else if ((state == S_RUN) && !en_fall) begin
      if (wr_len && ({1'b0, pos} >= eff_len)) begin
        pos_nx = 4'd0;
      end else if (step && !finish) begin
        if (oneshot_n) begin
          pos_nx = pos + 4'd1;
`ifdef SEQ_BOUNCE_EN
        end else if (bounce_n) begin
          if (dir) begin
            if ({1'b0, pos} >= top) begin
              dir_nx = 1'b0;
              pos_nx = (pos == 4'd0) ? 4'd0 : pos - 4'd1;
            end else begin
              pos_nx = pos + 4'd1;
            end
          end else begin
            if (pos == 4'd0) begin
              dir_nx = 1'b1;
              pos_nx = (top == 5'd0) ? 4'd0 : 4'd1;
            end else begin
              pos_nx = pos - 4'd1;
            end
          end
`endif
        end else begin
          pos_nx = (({1'b0, pos} + 5'd1) == eff_len) ? 4'd0 : pos + 4'd1;
        end
      end
    end
  end

  // Registers, counters, done flag and completion pulse.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      ctrl      <= '0;
      period    <= '0;
      len       <= '0;
      done_flag <= 1'b0;
      DONE_IRQ  <= 1'b0;
      pos       <= '0;
      pre_cnt   <= '0;
      per_cnt   <= '0;
      for (int i = 0; i < 16; i++) msg[i] <= '0;
`ifdef SEQ_BOUNCE_EN
      dir       <= 1'b1;
`endif
    end else begin
      if (wr_ctrl) ctrl <= BUS_DATA[2:0] & CTRL_MASK;
      if (wr_per)  period <= BUS_DATA;
      if (wr_len)  len <= BUS_DATA[4:0];
      if (wr_msg)  msg[midx] <= BUS_DATA[4:0];
      if (finish)
        done_flag <= 1'b1;
      else if (wr_stat && BUS_DATA[1])
        done_flag <= 1'b0;
      DONE_IRQ <= finish;
      pos      <= pos_nx;
`ifdef SEQ_BOUNCE_EN
      dir      <= dir_nx;
`endif
      if ((state_nx != S_RUN) || en_rise) begin
        pre_cnt <= '0;
        per_cnt <= '0;
      end else if (tick) begin
        pre_cnt <= '0;
        per_cnt <= step ? 8'd0 : per_cnt + 8'd1;
      end else begin
        pre_cnt <= pre_cnt + 1'b1;
      end
    end
  end

  // Window digits, refreshed every cycle from current POS/LEN/MSG.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      DIGIT_A <= '0;
      DIGIT_B <= '0;
      DIGIT_C <= '0;
      DIGIT_D <= '0;
    end else begin
      DIGIT_A <= msg[win_idx(pos, 5'd0, cur_len)];
      DIGIT_B <= msg[win_idx(pos, 5'd1, cur_len)];
      DIGIT_C <= msg[win_idx(pos, 5'd2, cur_len)];
      DIGIT_D <= msg[win_idx(pos, 5'd3, cur_len)];
    end
  end

  // Read data selection.
  always_comb begin
    rd_mux = 8'h00;
    if (off >= 8'd8) begin
      rd_mux = {3'b000, msg[midx]};
    end else begin
      unique case (off[2:0])
        3'd0:    rd_mux = {5'b0, ctrl};
        3'd1:    rd_mux = period;
        3'd2:    rd_mux = {3'b0, len};
        3'd3:    rd_mux = {6'b0, done_flag, BUSY};
        3'd4:    rd_mux = {4'b0, pos};
        default: rd_mux = 8'h00;
      endcase
    end
  end

  // Registered read capture and bus drive enable.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      drive   <= 1'b0;
      rd_data <= '0;
    end else begin
      drive <= in_win && !BUS_WE;
      if (in_win && !BUS_WE) rd_data <= rd_mux;
    end
  end

  // BUS_WE gates the driver directly so a write cycle is never contended.
  assign BUS_DATA = (drive && !BUS_WE) ? rd_data : 8'hzz;

endmodule
